lcd_bus_writer: RTL and testbench
=================================

# lcd_bus_writer

Parametrised 8080-style parallel write engine for the LCD panel interface, driving chip-select, write strobe, register-select and the data bus. It accepts command/data words over a valid/ready handshake, with programmable setup, strobe-low and strobe-high cycle counts, and streams bursts with chip-select held low between words. It sits between the frame/command sequencer and the LCD pads, and replaces the fixed-timing single-word write controller.

## Interface
- DATA_W, 16: LCD data bus width (8, 9, 16 or 18).
- T_SETUP, 1: cycles from CS low / data driven to the WR falling edge; must be ≥1.
- T_WRL, 1: cycles WR is held low; must be ≥1.
- T_WRH, 1: cycles WR is held high after the rising edge before the next word; must be ≥1.
- CNT_W, $clog2(max(T_SETUP,T_WRL,T_WRH))+1: phase counter width (derived).
- clk  in  1  system clock; one clock domain.
- rstn  in  1  asynchronous, active-low reset.
- wr_valid  in  1  upstream has a word.
- wr_ready  out  1  block accepts a word this cycle.
- wr_data  in  DATA_W  word to write.
- wr_rs  in  1  0 = command, 1 = data (drives LCD_RS).
- wr_last  in  1  final word of the burst; CS is released after it.
- word_done  out  1  one-cycle pulse in the final WR_H cycle of each word.
- busy  out  1  high whenever the state is not IDLE.
- LCD_CS  out  1  chip select, active low.
- LCD_WR  out  1  write strobe, active low; the panel latches on the rising edge.
- LCD_RS  out  1  register select.
- LCD_DB  out  DATA_W  data bus.

## Operation
- States: IDLE, SETUP, WR_L, WR_H, GAP. One phase counter is reloaded on every state entry.
- A word is accepted when wr_valid && wr_ready on a clock edge. That edge latches wr_data, wr_rs and wr_last.
- IDLE: CS=1, WR=1, wr_ready=1. On accept, go to SETUP.
- SETUP: CS=0, WR=1, DB/RS driven from the latched values. Lasts T_SETUP cycles, then WR_L.
- WR_L: CS=0, WR=0. Lasts T_WRL cycles, then WR_H.
- WR_H: CS=0, WR=1. Lasts T_WRH cycles.
  - wr_ready=1 only in the final WR_H cycle, and only if the latched last flag is 0.
  - word_done=1 in the final WR_H cycle.
  - Exit: if the latched last flag is 1, go to IDLE. Otherwise, on accept go to SETUP with the new word; with no accept, go to GAP.
- GAP: CS=0, WR=1, wr_ready=1. DB/RS hold the previous word. On accept, go to SETUP. There is no timeout.
- wr_ready is 0 in SETUP, in WR_L, and in WR_H except its final cycle.
- LCD_DB and LCD_RS change only on an accept edge. They hold their value in IDLE and GAP.
- All LCD_* outputs are registers with no combinational path from the inputs. wr_ready is decoded from state and counter only.
- If wr_valid drops without an accept, nothing happens; upstream may withdraw a word freely.
- Reset (asynchronous, any state, including mid-strobe) gives: state IDLE, LCD_CS=1, LCD_WR=1, LCD_RS=0, LCD_DB=0, wr_ready=1 on the first cycle after rstn rises, word_done=0, busy=0. A partially written word is dropped.

## Timing
- Accept at edge N: CS falls and DB/RS are valid from edge N. WR falls at edge N+T_SETUP. WR rises at edge N+T_SETUP+T_WRL.
- Word period in a back-to-back burst: T_SETUP+T_WRL+T_WRH cycles. With defaults this is 3 cycles per word.
- After a last word: CS rises T_SETUP+T_WRL+T_WRH cycles after its accept edge. The next accept is possible in the first IDLE cycle, so CS is high for at least 1 cycle between bursts.
- DB and RS are stable throughout the WR low phase and for T_WRH cycles after the WR rising edge.

## Test plan
- Defaults, single command 0x2A with wr_last=1 -> CS low for 3 cycles, WR low in cycle 2 only, RS=0, DB=0x002A, one word_done pulse, then IDLE with busy=0.
- Defaults, burst 0x0001, 0x0002, 0x0003 (data, wr_valid held high, last on the third) -> CS continuously low for 9 cycles, 3 WR low pulses 3 cycles apart, DB advances at each accept, 3 word_done pulses.
- T_SETUP=2, T_WRL=3, T_WRH=2, one word -> WR falls 2 cycles after CS falls, stays low 3 cycles, and CS rises 2 cycles after the WR rising edge.
- Burst with wr_valid low for 4 cycles mid-burst -> GAP entered, CS stays 0, WR stays 1, DB holds the old word; the next word resumes with normal SETUP timing.
- rstn asserted in the middle of WR_L -> LCD_WR=1, LCD_CS=1 and DB=0 immediately; no word_done; after release, a new single write completes normally.
- Random wr_valid toggling over a 200-word stream -> every accepted word appears exactly once on DB at a WR rising edge, in order, with correct RS, and no word is accepted while wr_ready=0.

Source files
------------

// File: rtl/lcd_bus_writer_if.sv
// Upstream write handshake for the LCD bus writer: one command/data word per
// wr_valid && wr_ready edge, with register-select and end-of-burst flag.
interface lcd_bus_writer_if #(
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rs;
    logic              wr_last;

    modport master (
        output wr_valid, wr_data, wr_rs, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_rs, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// 8080-style parallel LCD write engine: programmable setup / strobe-low / strobe-high
// phases, with chip-select held low across back-to-back words of a burst.
module lcd_bus_writer #(
    parameter int DATA_W  = 16,
    parameter int T_SETUP = 1,
    parameter int T_WRL   = 1,
    parameter int T_WRH   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    lcd_bus_writer_if.slave   wr_if,
    output logic              word_done,
    output logic              busy,
    output logic              LCD_CS,
    output logic              LCD_WR,
    output logic              LCD_RS,
    output logic [DATA_W-1:0] LCD_DB
);
    localparam int T_MAX = (T_SETUP > T_WRL) ? ((T_SETUP > T_WRH) ? T_SETUP : T_WRH)
                                             : ((T_WRL > T_WRH) ? T_WRL : T_WRH);
    localparam int CNT_W = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, WR_L, WR_H, GAP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rs_q, rs_d;
    logic              last_q, last_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              cnt_zero;
    logic              accept;

    assign cnt_zero = (cnt_q == '0);

    // Ready depends only on registered state so upstream sees no input-to-output path.
    assign wr_if.wr_ready = (state_q == IDLE) || (state_q == GAP) ||
                            ((state_q == WR_H) && cnt_zero && !last_q);
    assign accept = wr_if.wr_valid && wr_if.wr_ready;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE, GAP: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = WR_L;
                    cnt_d   = CNT_W'(T_WRL - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_L: begin
                if (cnt_zero) begin
                    state_d = WR_H;
                    cnt_d   = CNT_W'(T_WRH - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_H: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (last_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(T_SETUP - 1);
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            data_d = wr_if.wr_data;
            rs_d   = wr_if.wr_rs;
            last_d = wr_if.wr_last;
        end

        // Pin values are computed from the next state so the pads come straight off flops.
        cs_d   = (state_d == IDLE);
        wr_d   = (state_d != WR_L);
        done_d = (state_d == WR_H) && (cnt_d == '0);
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign LCD_CS    = cs_q;
    assign LCD_WR    = wr_q;
    assign LCD_RS    = rs_q;
    assign LCD_DB    = data_q;
    assign word_done = done_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: default-timing instance for single, burst, gap,
// reset and random-stream cases, plus a slow-timing instance (2/3/2).
module tb_lcd_bus_writer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lcd_bus_writer_if #(.DATA_W(DW)) u_if0 ();
    lcd_bus_writer_if #(.DATA_W(DW)) u_if1 ();

    logic          done0, busy0, cs0, wr0, rs0;
    logic [DW-1:0] db0;
    logic          done1, busy1, cs1, wr1, rs1;
    logic [DW-1:0] db1;

    lcd_bus_writer #(.DATA_W(DW), .T_SETUP(1), .T_WRL(1), .T_WRH(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .wr_if(u_if0.slave),
        .word_done(done0), .busy(busy0),
        .LCD_CS(cs0), .LCD_WR(wr0), .LCD_RS(rs0), .LCD_DB(db0)
    );

    lcd_bus_writer #(.DATA_W(DW), .T_SETUP(2), .T_WRL(3), .T_WRH(2)) u_dut1 (
        .clk(clk), .rstn(rstn), .wr_if(u_if1.slave),
        .word_done(done1), .busy(busy1),
        .LCD_CS(cs1), .LCD_WR(wr1), .LCD_RS(rs1), .LCD_DB(db1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard on the default instance: accepted words must reappear in order at WR rising edges.
    logic [DW:0]   exp_q[$];
    logic          prev_wr = 1'b1;
    logic          prev_acc = 1'b0;
    logic [DW-1:0] prev_db = '0;
    int            rise_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rstn) begin
            exp_q.delete();
            prev_wr  = 1'b1;
            prev_acc = 1'b0;
            prev_db  = '0;
        end else begin
            if (db0 !== prev_db)
                check("db_change_without_accept", 32'(prev_acc), 32'd1);
            if (wr0 && !prev_wr) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    check("strobe_without_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_db", 32'(db0), 32'(e[DW-1:0]));
                    check("sb_rs", 32'(rs0), 32'(e[DW]));
                end
            end
            if (done0) done_cnt++;
            prev_acc = u_if0.wr_valid && u_if0.wr_ready;
            if (prev_acc) exp_q.push_back({u_if0.wr_rs, u_if0.wr_data});
            prev_wr = wr0;
            prev_db = db0;
        end
    end

    task automatic drive0(input logic v, input logic [DW-1:0] d, input logic rs, input logic last);
        u_if0.wr_valid = v;
        u_if0.wr_data  = d;
        u_if0.wr_rs    = rs;
        u_if0.wr_last  = last;
    endtask

    // One default-timing word with last=1: 3 cycles of CS low, WR low only in the middle one.
    task automatic run_single(input string tag, input logic [DW-1:0] d, input logic rs);
        logic exp_wr[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_cs[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_done[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        check({tag, "_ready_idle"}, 32'(u_if0.wr_ready), 32'd1);
        drive0(1'b1, d, rs, 1'b1);
        tick();
        u_if0.wr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            check($sformatf("%s_cs%0d", tag, c), 32'(cs0), 32'(exp_cs[c]));
            check($sformatf("%s_wr%0d", tag, c), 32'(wr0), 32'(exp_wr[c]));
            check($sformatf("%s_done%0d", tag, c), 32'(done0), 32'(exp_done[c]));
            check($sformatf("%s_busy%0d", tag, c), 32'(busy0), 32'(c < 3));
            check($sformatf("%s_db%0d", tag, c), 32'(db0), 32'(d));
            check($sformatf("%s_rs%0d", tag, c), 32'(rs0), 32'(rs));
        end
        check({tag, "_ready_end"}, 32'(u_if0.wr_ready), 32'd1);
    endtask

    initial begin
        logic          acc;
        int            idx;
        int            cyc;
        logic [DW-1:0] words[3];
        logic [DW-1:0] rwords[200];
        logic          rrs[200];
        logic          rlast[200];

        drive0(1'b0, '0, 1'b0, 1'b0);
        u_if1.wr_valid = 1'b0;
        u_if1.wr_data  = '0;
        u_if1.wr_rs    = 1'b0;
        u_if1.wr_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Reset state
        check("rst_cs", 32'(cs0), 32'd1);
        check("rst_wr", 32'(wr0), 32'd1);
        check("rst_rs", 32'(rs0), 32'd0);
        check("rst_db", 32'(db0), 32'd0);
        check("rst_ready", 32'(u_if0.wr_ready), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // Single command 0x2A
        run_single("single", 16'h002A, 1'b0);
        tick();

        // Burst of three data words, valid held high
        words = '{16'h0001, 16'h0002, 16'h0003};
        idx = 0;
        drive0(1'b1, words[0], 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            acc = u_if0.wr_valid && u_if0.wr_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) drive0(1'b1, words[idx], 1'b1, idx == 2);
                else u_if0.wr_valid = 1'b0;
            end
            check($sformatf("burst_cs%0d", c), 32'(cs0), 32'(c >= 9));
            check($sformatf("burst_wr%0d", c), 32'(wr0), 32'(!(c < 9 && c % 3 == 1)));
            check($sformatf("burst_done%0d", c), 32'(done0), 32'(c < 9 && c % 3 == 2));
            check($sformatf("burst_db%0d", c), 32'(db0), (c < 9) ? 32'(c / 3 + 1) : 32'd3);
        end

        // Slow timing instance: T_SETUP=2, T_WRL=3, T_WRH=2
        u_if1.wr_valid = 1'b1;
        u_if1.wr_data  = 16'h1234;
        u_if1.wr_rs    = 1'b1;
        u_if1.wr_last  = 1'b1;
        tick();
        u_if1.wr_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            check($sformatf("slow_cs%0d", c), 32'(cs1), 32'(c >= 7));
            check($sformatf("slow_wr%0d", c), 32'(wr1), 32'(!(c >= 2 && c <= 4)));
            check($sformatf("slow_done%0d", c), 32'(done1), 32'(c == 6));
        end
        check("slow_db", 32'(db1), 32'h1234);
        check("slow_ready_end", 32'(u_if1.wr_ready), 32'd1);

        // Gap mid-burst: valid low for 4 cycles after the first word
        words = '{16'h0011, 16'h0022, 16'h0000};
        idx = 0;
        drive0(1'b1, words[0], 1'b1, 1'b0);
        for (int c = 0; c < 9; c++) begin
            acc = u_if0.wr_valid && u_if0.wr_ready;
            tick();
            if (acc) idx++;
            drive0((idx < 2) && (c >= 4), words[idx < 2 ? idx : 1], idx != 0 ? 1'b0 : 1'b1, 1'b1);
            check($sformatf("gap_cs%0d", c), 32'(cs0), 32'(c >= 8));
            check($sformatf("gap_wr%0d", c), 32'(wr0), 32'(c != 1 && c != 6));
            check($sformatf("gap_done%0d", c), 32'(done0), 32'(c == 2 || c == 7));
            check($sformatf("gap_db%0d", c), 32'(db0), (c < 5) ? 32'h11 : 32'h22);
            check($sformatf("gap_rs%0d", c), 32'(rs0), 32'(c < 5));
        end
        tick();

        // Reset asserted during WR_L
        drive0(1'b1, 16'h0055, 1'b1, 1'b1);
        tick();
        u_if0.wr_valid = 1'b0;
        tick();
        check("mid_wrl", 32'(wr0), 32'd0);
        rstn = 1'b0;
        #1;
        check("mid_rst_wr", 32'(wr0), 32'd1);
        check("mid_rst_cs", 32'(cs0), 32'd1);
        check("mid_rst_db", 32'(db0), 32'd0);
        check("mid_rst_rs", 32'(rs0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        repeat (2) tick();
        check("mid_rst_done_hold", 32'(done0), 32'd0);
        rstn = 1'b1;
        tick();
        check("post_rst_done", 32'(done0), 32'd0);
        run_single("post_rst", 16'h00A5, 1'b1);
        tick();

        // Random valid over a 200-word stream
        for (int i = 0; i < 200; i++) begin
            rwords[i] = DW'($urandom_range(0, 16'hFFFF));
            rrs[i]    = 1'($urandom_range(0, 1));
            rlast[i]  = (i == 199) || ($urandom_range(0, 7) == 0);
        end
        rise_cnt = 0;
        done_cnt = 0;
        idx = 0;
        cyc = 0;
        while (idx < 200 && cyc < 20000) begin
            drive0($urandom_range(0, 2) != 0, rwords[idx], rrs[idx], rlast[idx]);
            acc = u_if0.wr_valid && u_if0.wr_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        u_if0.wr_valid = 1'b0;
        check("rand_words_accepted", 32'(idx), 32'd200);
        repeat (8) tick();
        check("rand_strobes", 32'(rise_cnt), 32'd200);
        check("rand_done_pulses", 32'(done_cnt), 32'd200);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_idle_cs", 32'(cs0), 32'd1);
        check("rand_idle_busy", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
